// File: rtl/id_stage.sv
// MIPS decode stage: decodes IF/ID, resolves branch/jump redirects, selects forwarded operands
// and registers the result into ID/EX with bubble-on-stall and flush-on-exception/eret.
module id_stage #(
    parameter logic [4:0] EXC_RI   = 5'd10,
    parameter logic [4:0] EXC_NONE = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        ErrSignal,
    input  logic        eretEn,
    input  logic [31:0] PC_D,
    input  logic [31:0] PC_4_D,
    input  logic [31:0] Instr_D,
    input  logic        Err_D,
    input  logic [4:0]  ErrStat_D,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] grf_rd1,
    input  logic [31:0] grf_rd2,
    input  logic [1:0]  fwd_rs,
    input  logic [1:0]  fwd_rt,
    input  logic [31:0] fwd_E,
    input  logic [31:0] fwd_M,
    output logic        branch,
    output logic        jump,
    output logic [31:0] branch_addr32,
    output logic [31:0] jump_addr32,
    output logic [31:0] PC_E,
    output logic [31:0] PC_4_E,
    output logic [31:0] Instr_E,
    output logic [31:0] RS_E,
    output logic [31:0] RT_E,
    output logic [31:0] EXT_E,
    output logic        Err_E,
    output logic [4:0]  ErrStat_E,
    output logic        BD_E
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    localparam logic [4:0] C0_MF      = 5'h00;
    localparam logic [4:0] C0_MT      = 5'h04;
    localparam logic [31:0] ERET_WORD = 32'h4200_0018;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_field;
    logic [15:0] imm16;

    assign opcode   = Instr_D[31:26];
    assign funct    = Instr_D[5:0];
    assign rs_field = Instr_D[25:21];
    assign imm16    = Instr_D[15:0];

    assign rs_addr  = Instr_D[25:21];
    assign rt_addr  = Instr_D[20:16];

    logic is_addu, is_subu, is_jr, is_nop;
    logic is_ori, is_lui, is_lw, is_sw;
    logic is_beq, is_bne, is_j, is_jal;
    logic is_mfc0, is_mtc0, is_eret;
    logic reserved;
    logic is_jb;

    assign is_nop  = (Instr_D == 32'd0);
    assign is_addu = (opcode == OP_SPECIAL) && (funct == FN_ADDU);
    assign is_subu = (opcode == OP_SPECIAL) && (funct == FN_SUBU);
    assign is_jr   = (opcode == OP_SPECIAL) && (funct == FN_JR);
    assign is_ori  = (opcode == OP_ORI);
    assign is_lui  = (opcode == OP_LUI);
    assign is_lw   = (opcode == OP_LW);
    assign is_sw   = (opcode == OP_SW);
    assign is_beq  = (opcode == OP_BEQ);
    assign is_bne  = (opcode == OP_BNE);
    assign is_j    = (opcode == OP_J);
    assign is_jal  = (opcode == OP_JAL);
    assign is_mfc0 = (opcode == OP_COP0) && (rs_field == C0_MF);
    assign is_mtc0 = (opcode == OP_COP0) && (rs_field == C0_MT);
    assign is_eret = (Instr_D == ERET_WORD);

    assign reserved = ~(is_nop | is_addu | is_subu | is_jr | is_ori | is_lui |
                        is_lw | is_sw | is_beq | is_bne | is_j | is_jal |
                        is_mfc0 | is_mtc0 | is_eret);

    assign is_jb = is_beq | is_bne | is_j | is_jal | is_jr;

    logic [31:0] rs_val;
    logic [31:0] rt_val;

    always_comb begin
        rs_val = grf_rd1;
        case (fwd_rs)
            2'd1:    rs_val = fwd_E;
            2'd2:    rs_val = fwd_M;
            default: rs_val = grf_rd1;
        endcase
    end

    always_comb begin
        rt_val = grf_rd2;
        case (fwd_rt)
            2'd1:    rt_val = fwd_E;
            2'd2:    rt_val = fwd_M;
            default: rt_val = grf_rd2;
        endcase
    end

    logic [31:0] ext_val;

    always_comb begin
        ext_val = 32'd0;
        if (is_ori)
            ext_val = {16'd0, imm16};
        else if (is_lui)
            ext_val = {imm16, 16'd0};
        else if (is_lw || is_sw || is_beq || is_bne)
            ext_val = {{16{imm16[15]}}, imm16};
    end

    // A held, faulting or flushed instruction must not steer fetch.
    logic redirect_ok;
    logic branch_taken;

    assign redirect_ok   = ~(Stall | Err_D | ErrSignal | eretEn);
    assign branch_taken  = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
    assign branch        = redirect_ok & branch_taken;
    assign jump          = redirect_ok & (is_j | is_jal | is_jr);
    assign branch_addr32 = PC_4_D + {{14{imm16[15]}}, imm16, 2'b00};
    assign jump_addr32   = is_jr ? rs_val : {PC_4_D[31:28], Instr_D[25:0], 2'b00};

    logic        dec_err;
    logic [4:0]  dec_stat;
    logic [31:0] dec_instr;

    always_comb begin
        dec_err   = 1'b0;
        dec_stat  = EXC_NONE;
        dec_instr = Instr_D;
        if (Err_D) begin
            dec_err   = 1'b1;
            dec_stat  = ErrStat_D;
            dec_instr = 32'd0;
        end else if (reserved) begin
            dec_err   = 1'b1;
            dec_stat  = EXC_RI;
            dec_instr = 32'd0;
        end
    end

    logic prev_jb;

    always_ff @(posedge clk) begin
        if (reset || ErrSignal || eretEn) begin
            PC_E      <= 32'd0;
            PC_4_E    <= 32'd0;
            Instr_E   <= 32'd0;
            RS_E      <= 32'd0;
            RT_E      <= 32'd0;
            EXT_E     <= 32'd0;
            Err_E     <= 1'b0;
            ErrStat_E <= EXC_NONE;
            BD_E      <= 1'b0;
            prev_jb   <= 1'b0;
        end else if (Stall) begin
            // Bubble keeps PC and BD so an exception on it reports a valid EPC.
            PC_E      <= PC_D;
            PC_4_E    <= PC_4_D;
            Instr_E   <= 32'd0;
            RS_E      <= 32'd0;
            RT_E      <= 32'd0;
            EXT_E     <= 32'd0;
            Err_E     <= 1'b0;
            ErrStat_E <= EXC_NONE;
            BD_E      <= prev_jb;
        end else begin
            PC_E      <= PC_D;
            PC_4_E    <= PC_4_D;
            Instr_E   <= dec_instr;
            RS_E      <= rs_val;
            RT_E      <= rt_val;
            EXT_E     <= ext_val;
            Err_E     <= dec_err;
            ErrStat_E <= dec_stat;
            BD_E      <= prev_jb;
            prev_jb   <= is_jb;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX contents are queued when stimulus is driven
// and compared after the following clock edge; redirect outputs are checked before the edge.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset, Stall, ErrSignal, eretEn;
    logic [31:0] PC_D, PC_4_D, Instr_D;
    logic        Err_D;
    logic [4:0]  ErrStat_D;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] grf_rd1, grf_rd2;
    logic [1:0]  fwd_rs, fwd_rt;
    logic [31:0] fwd_E, fwd_M;
    logic        branch, jump;
    logic [31:0] branch_addr32, jump_addr32;
    logic [31:0] PC_E, PC_4_E, Instr_E, RS_E, RT_E, EXT_E;
    logic        Err_E;
    logic [4:0]  ErrStat_E;
    logic        BD_E;

    id_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .ErrSignal(ErrSignal), .eretEn(eretEn),
        .PC_D(PC_D), .PC_4_D(PC_4_D), .Instr_D(Instr_D), .Err_D(Err_D), .ErrStat_D(ErrStat_D),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .grf_rd1(grf_rd1), .grf_rd2(grf_rd2),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_E(fwd_E), .fwd_M(fwd_M),
        .branch(branch), .jump(jump), .branch_addr32(branch_addr32), .jump_addr32(jump_addr32),
        .PC_E(PC_E), .PC_4_E(PC_4_E), .Instr_E(Instr_E), .RS_E(RS_E), .RT_E(RT_E), .EXT_E(EXT_E),
        .Err_E(Err_E), .ErrStat_E(ErrStat_E), .BD_E(BD_E)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc, pc4, instr, rs, rt, ext;
        logic        err;
        logic [4:0]  stat;
        logic        bd;
    } idex_t;

    idex_t sb[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ext, input logic err, input logic [4:0] stat,
                        input logic bd);
        idex_t e;
        e.tag = tag; e.pc = pc; e.pc4 = pc4; e.instr = instr; e.rs = rs; e.rt = rt;
        e.ext = ext; e.err = err; e.stat = stat; e.bd = bd;
        sb.push_back(e);
    endtask

    task automatic push_flush(input string tag);
        push(tag, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd31, 1'b0);
    endtask

    task automatic redir(input string tag, input logic b, input logic [31:0] ba,
                         input logic j, input logic [31:0] ja);
        #1;
        chk({tag, ".branch"}, 32'(branch), 32'(b));
        if (b) chk({tag, ".branch_addr"}, branch_addr32, ba);
        chk({tag, ".jump"}, 32'(jump), 32'(j));
        if (j) chk({tag, ".jump_addr"}, jump_addr32, ja);
    endtask

    task automatic tick();
        idex_t e;
        @(posedge clk);
        #1;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".PC_E"},      PC_E,    e.pc);
            chk({e.tag, ".PC_4_E"},    PC_4_E,  e.pc4);
            chk({e.tag, ".Instr_E"},   Instr_E, e.instr);
            chk({e.tag, ".RS_E"},      RS_E,    e.rs);
            chk({e.tag, ".RT_E"},      RT_E,    e.rt);
            chk({e.tag, ".EXT_E"},     EXT_E,   e.ext);
            chk({e.tag, ".Err_E"},     32'(Err_E),     32'(e.err));
            chk({e.tag, ".ErrStat_E"}, 32'(ErrStat_E), 32'(e.stat));
            chk({e.tag, ".BD_E"},      32'(BD_E),      32'(e.bd));
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] r1, input logic [31:0] r2);
        PC_D = pc; PC_4_D = pc + 32'd4; Instr_D = instr; grf_rd1 = r1; grf_rd2 = r2;
    endtask

    localparam logic [31:0] BEQ_M1  = 32'h1022_FFFF;
    localparam logic [31:0] ADDU    = 32'h0022_1821;
    localparam logic [31:0] JR31    = 32'h03E0_0008;
    localparam logic [31:0] RSVD    = 32'hFC00_0000;
    localparam logic [31:0] ORI     = 32'h3401_8001;
    localparam logic [31:0] LUI     = 32'h3C01_8001;
    localparam logic [31:0] LW      = 32'h8C01_8001;
    localparam logic [31:0] BNE_P2  = 32'h1422_0002;
    localparam logic [31:0] J_TGT   = 32'h0810_0010;

    initial begin
        reset = 1'b1; Stall = 1'b0; ErrSignal = 1'b0; eretEn = 1'b0;
        Err_D = 1'b0; ErrStat_D = 5'd0;
        fwd_rs = 2'd0; fwd_rt = 2'd0; fwd_E = 32'hEEEE_0000; fwd_M = 32'hDDDD_0000;
        drive(32'h3000, BEQ_M1, 32'd1, 32'd2);

        push_flush("reset0");
        push_flush("reset1");
        tick();
        tick();
        redir("reset", 1'b0, 32'd0, 1'b0, 32'd0);
        chk("rs_addr", 32'(rs_addr), 32'd1);
        chk("rt_addr", 32'(rt_addr), 32'd2);

        reset = 1'b0;
        drive(32'h3008, BEQ_M1, 32'h5, 32'h5);
        redir("beq", 1'b1, 32'h3008, 1'b0, 32'd0);
        push("beq", 32'h3008, 32'h300C, BEQ_M1, 32'h5, 32'h5, 32'hFFFF_FFFF, 1'b0, 5'd31, 1'b0);
        tick();

        drive(32'h300C, ADDU, 32'h7, 32'h9);
        redir("addu", 1'b0, 32'd0, 1'b0, 32'd0);
        push("addu_ds", 32'h300C, 32'h3010, ADDU, 32'h7, 32'h9, 32'd0, 1'b0, 5'd31, 1'b1);
        tick();

        drive(32'h3010, JR31, 32'h1111, 32'h22);
        fwd_rs = 2'd2; fwd_M = 32'h3040; Stall = 1'b1;
        redir("jr_stall", 1'b0, 32'd0, 1'b0, 32'd0);
        push("jr_bubble", 32'h3010, 32'h3014, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd31, 1'b0);
        tick();
        Stall = 1'b0;
        redir("jr", 1'b0, 32'd0, 1'b1, 32'h3040);
        push("jr", 32'h3010, 32'h3014, JR31, 32'h3040, 32'h22, 32'd0, 1'b0, 5'd31, 1'b0);
        tick();

        fwd_rs = 2'd1; fwd_rt = 2'd3; fwd_E = 32'hA5A5_0001;
        drive(32'h3014, RSVD, 32'hA, 32'hB);
        redir("rsvd", 1'b0, 32'd0, 1'b0, 32'd0);
        push("rsvd_ds", 32'h3014, 32'h3018, 32'd0, 32'hA5A5_0001, 32'hB, 32'd0, 1'b1, 5'd10, 1'b1);
        tick();
        fwd_rs = 2'd0; fwd_rt = 2'd0;

        drive(32'h3018, RSVD, 32'hA, 32'hB);
        Err_D = 1'b1; ErrStat_D = 5'd4;
        push("err_d", 32'h3018, 32'h301C, 32'd0, 32'hA, 32'hB, 32'd0, 1'b1, 5'd4, 1'b0);
        tick();
        Err_D = 1'b0; ErrStat_D = 5'd0;

        drive(32'h301C, ORI, 32'h3, 32'h4);
        push("ori", 32'h301C, 32'h3020, ORI, 32'h3, 32'h4, 32'h0000_8001, 1'b0, 5'd31, 1'b0);
        tick();
        drive(32'h3020, LUI, 32'h3, 32'h4);
        push("lui", 32'h3020, 32'h3024, LUI, 32'h3, 32'h4, 32'h8001_0000, 1'b0, 5'd31, 1'b0);
        tick();
        drive(32'h3024, LW, 32'h3, 32'h4);
        push("lw", 32'h3024, 32'h3028, LW, 32'h3, 32'h4, 32'hFFFF_8001, 1'b0, 5'd31, 1'b0);
        tick();

        drive(32'h4000, BNE_P2, 32'h1, 32'h2);
        Err_D = 1'b1;
        redir("bne_errd", 1'b0, 32'd0, 1'b0, 32'd0);
        Err_D = 1'b0;
        redir("bne", 1'b1, 32'h400C, 1'b0, 32'd0);
        push("bne", 32'h4000, 32'h4004, BNE_P2, 32'h1, 32'h2, 32'h0000_0002, 1'b0, 5'd31, 1'b0);
        tick();

        Stall = 1'b1; ErrSignal = 1'b1;
        redir("flush_bne", 1'b0, 32'd0, 1'b0, 32'd0);
        push_flush("stall_flush");
        tick();
        Stall = 1'b0; ErrSignal = 1'b0;

        drive(32'h5000, ADDU, 32'h1, 32'h2);
        push("post_flush", 32'h5000, 32'h5004, ADDU, 32'h1, 32'h2, 32'd0, 1'b0, 5'd31, 1'b0);
        tick();

        drive(32'h5000_0000, J_TGT, 32'h0, 32'h0);
        eretEn = 1'b1;
        redir("j_eret", 1'b0, 32'd0, 1'b0, 32'd0);
        push_flush("eret_flush");
        tick();
        eretEn = 1'b0;
        redir("j", 1'b0, 32'd0, 1'b1, 32'h5040_0040);
        push("j", 32'h5000_0000, 32'h5000_0004, J_TGT, 32'h0, 32'h0, 32'd0, 1'b0, 5'd31, 1'b0);
        tick();
        drive(32'h5000_0004, ADDU, 32'h6, 32'h7);
        push("j_ds", 32'h5000_0004, 32'h5000_0008, ADDU, 32'h6, 32'h7, 32'd0, 1'b0, 5'd31, 1'b1);
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the five-stage MIPS pipeline: consumes the IF/ID register (PC, PC+4, instruction, fetch exception) produced by the fetch stage, decodes the instruction, resolves branches and jumps, and returns the redirect to fetch. It selects forwarded operands, extends the immediate and detects reserved instructions. It also tracks branch-delay-slot membership and drives the ID/EX pipeline register, inserting bubbles on stall and clearing on exception or eret.

## Interface
Parameters:
- EXC_RI, 5'd10, exception code for a reserved instruction.
- EXC_NONE, 5'd31, code meaning "no exception".

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- Stall  in  1  hazard unit hold request; ID/EX receives a bubble.
- ErrSignal  in  1  exception taken this cycle; flush.
- eretEn  in  1  eret taken this cycle; flush.
- PC_D, PC_4_D, Instr_D  in  32 each  IF/ID contents.
- Err_D  in  1  fetch exception flag.
- ErrStat_D  in  5  fetch exception code.
- rs_addr, rt_addr  out  5 each  GRF read addresses, Instr_D[25:21] and Instr_D[20:16].
- grf_rd1, grf_rd2  in  32 each  GRF read data.
- fwd_rs, fwd_rt  in  2 each  operand source: 0 GRF, 1 fwd_E, 2 fwd_M, 3 GRF.
- fwd_E, fwd_M  in  32 each  forwarded results.
- branch, jump  out  1 each  redirect requests to fetch (combinational).
- branch_addr32, jump_addr32  out  32 each  redirect targets (combinational).
- PC_E, PC_4_E, Instr_E, RS_E, RT_E, EXT_E  out  32 each  ID/EX register.
- Err_E  out  1; ErrStat_E  out  5; BD_E  out  1  delay-slot flag.

## Operation
- Supported set: addu, subu, ori, lui, lw, sw, beq, bne, j, jal, jr, mfc0, mtc0, eret, and all-zero nop. Any other opcode/funct is reserved.
- Operands: RS = mux(fwd_rs), RT = mux(fwd_rt). Select values 0 and 3 both choose GRF.
- EXT:
  - ori: zero-extended imm16.
  - lui: {imm16, 16'b0}.
  - lw, sw, beq, bne: sign-extended imm16.
  - all others: 0.
- branch = (beq & RS==RT) | (bne & RS!=RT).
- branch_addr32 = PC_4_D + (sext(imm16) << 2), mod 2^32.
- jump = j | jal | jr.
- jump_addr32 = {PC_4_D[31:28], Instr_D[25:0], 2'b00} for j/jal; RS for jr.
- branch and jump are forced 0 when Stall, Err_D, ErrSignal or eretEn is high.
- Exception priority:
  - Err_D=1: pass ErrStat_D; Instr_E=0.
  - Otherwise, reserved instruction: Err_E=1, ErrStat_E=EXC_RI, Instr_E=0.
  - Otherwise: Err_E=0, ErrStat_E=EXC_NONE.
- Delay slot: internal register prev_jb. prev_jb <= (beq|bne|j|jal|jr) of Instr_D on each accepted (non-stall, non-flush) cycle. BD_E <= prev_jb on accept.

## Timing
- ID/EX update priority at posedge clk:
  1. reset | ErrSignal | eretEn: all 32-bit outputs 0, Err_E=0, ErrStat_E=31, BD_E=0, prev_jb=0.
  2. Stall: bubble. Instr_E=0, RS_E=RT_E=EXT_E=0, Err_E=0, ErrStat_E=31. PC_E=PC_D, PC_4_E=PC_4_D, BD_E=prev_jb; these are kept so the EPC of a bubble is valid. prev_jb is unchanged.
  3. Otherwise: accept the decoded instruction.
- Latency: one cycle IF/ID to ID/EX. The redirect is zero-cycle combinational and consumed by fetch at the same edge.
- Reset value of every registered output: as in case 1. Combinational outputs follow the inputs, gated as above.
- Simultaneous Stall with ErrSignal: flush wins.
- A branch in decode under Stall issues no redirect until the stall drops. It then redirects exactly once.
- Reserved instruction in a delay slot: Err_E=1, ErrStat_E=10, BD_E=1.

## Test plan
- Reset high for 2 cycles with Instr_D=beq: after the edge, all outputs are 0, ErrStat_E=31, branch=0, jump=0.
- beq $1,$2,-1 at PC_D=0x3008 with both operands 0x5 -> branch=1, branch_addr32=0x3008. Next cycle: a delay-slot addu gives BD_E=1, PC_E=0x300C.
- jr with fwd_rs=2 and fwd_M=0x3040 -> jump=1, jump_addr32=0x3040. With Stall=1 -> jump=0; ID/EX receives a bubble with Instr_E=0 and PC_E=PC_D.
- Instr_D=0xFC000000 -> Err_E=1, ErrStat_E=10, Instr_E=0. With Err_D=1 and ErrStat_D=4 on the same instruction -> ErrStat_E=4.
- ori with imm 0x8001 -> EXT_E=0x00008001. lui with 0x8001 -> 0x80010000. lw with 0x8001 -> 0xFFFF8001.
- Stall and ErrSignal both high -> flush values, prev_jb=0. The next instruction after a pending branch gives BD_E=0.
